// File: rtl/fc_sequencer.sv
// Fully-connected layer sequencer: streams N_IN activation/weight pairs per neuron,
// accumulates signed products, emits each neuron's upper 32 bits and tracks the argmax.
module fc_sequencer #(
   parameter int unsigned N_IN  = 1152,
   parameter int unsigned N_OUT = 10,
   parameter int unsigned ACT_W = 69,
   parameter int unsigned WGT_W = 32,
   parameter int unsigned ACC_W = 101
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             rd_en,
   output logic [10:0]      act_addr,
   output logic [13:0]      wgt_addr,
   input  logic [ACT_W-1:0] act_data,
   input  logic [WGT_W-1:0] wgt_data,
   output logic             res_valid,
   output logic [3:0]       res_idx,
   output logic [31:0]      res_data,
   output logic [3:0]       argmax,
   output logic             done
);

   typedef enum logic [2:0] {
      StIdle,
      StRun,
      StDrain,
      StEmit,
      StFin
   } state_e;

   localparam logic [10:0] LastM      = 11'(N_IN - 1);
   localparam logic [3:0]  LastNeuron = 4'(N_OUT - 1);

   state_e              state_q;
   logic [3:0]          neuron_q;
   logic [ACC_W-1:0]    acc_q;
   logic signed [31:0]  best_q;

   logic signed [ACC_W-1:0] wgt_ext;
   logic signed [ACC_W-1:0] act_ext;
   logic        [ACC_W-1:0] prod;
   logic        [ACC_W-1:0] acc_sum;

   // Low ACC_W bits of the product are identical for signed and unsigned multiply once
   // both operands are extended correctly, so wrap-around falls out naturally.
   always_comb begin
      wgt_ext = ACC_W'($signed(wgt_data));
      act_ext = ACC_W'({1'b0, act_data});
      prod    = wgt_ext * act_ext;
      acc_sum = acc_q + prod;
   end

   // act_addr doubles as the per-neuron index m.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         neuron_q  <= '0;
         acc_q     <= '0;
         best_q    <= '0;
         busy      <= 1'b0;
         rd_en     <= 1'b0;
         act_addr  <= '0;
         wgt_addr  <= '0;
         res_valid <= 1'b0;
         res_idx   <= '0;
         res_data  <= '0;
         argmax    <= '0;
         done      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q  <= StRun;
                  busy     <= 1'b1;
                  rd_en    <= 1'b1;
                  act_addr <= '0;
                  wgt_addr <= '0;
                  neuron_q <= '0;
                  acc_q    <= '0;
                  best_q   <= '0;
               end
            end

            StRun: begin
               // Data for the previous read arrives this cycle; none yet at m=0.
               if (act_addr != '0) begin
                  acc_q <= acc_sum;
               end
               if (act_addr == LastM) begin
                  state_q <= StDrain;
                  rd_en   <= 1'b0;
               end else begin
                  act_addr <= act_addr + 11'd1;
                  wgt_addr <= wgt_addr + 14'd1;
               end
            end

            StDrain: begin
               acc_q     <= acc_sum;
               res_valid <= 1'b1;
               res_idx   <= neuron_q;
               res_data  <= acc_sum[ACC_W-1 -: 32];
               state_q   <= StEmit;
            end

            StEmit: begin
               res_valid <= 1'b0;
               acc_q     <= '0;
               if (neuron_q == '0 || $signed(res_data) > best_q) begin
                  best_q <= $signed(res_data);
                  argmax <= neuron_q;
               end
               if (neuron_q == LastNeuron) begin
                  state_q <= StFin;
                  done    <= 1'b1;
               end else begin
                  // Weight rows are contiguous, so the next neuron starts one past the last.
                  neuron_q <= neuron_q + 4'd1;
                  act_addr <= '0;
                  wgt_addr <= wgt_addr + 14'd1;
                  rd_en    <= 1'b1;
                  state_q  <= StRun;
               end
            end

            StFin: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_q <= StIdle;
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fc_sequencer.sv
// Directed bench for fc_sequencer: memory model, scoreboard queue of expected results,
// timing and argmax checks per pass.
module tb_fc_sequencer;

   localparam int N_IN     = 1152;
   localparam int N_OUT    = 10;
   localparam int ACT_W    = 69;
   localparam int WGT_W    = 32;
   localparam int ACC_W    = 101;
   localparam int PASS_CYC = 1 + N_OUT * (N_IN + 2);

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             busy;
   logic             rd_en;
   logic [10:0]      act_addr;
   logic [13:0]      wgt_addr;
   logic [ACT_W-1:0] act_data;
   logic [WGT_W-1:0] wgt_data;
   logic             res_valid;
   logic [3:0]       res_idx;
   logic [31:0]      res_data;
   logic [3:0]       argmax;
   logic             done;

   fc_sequencer #(
      .N_IN (N_IN),
      .N_OUT(N_OUT),
      .ACT_W(ACT_W),
      .WGT_W(WGT_W),
      .ACC_W(ACC_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .busy     (busy),
      .rd_en    (rd_en),
      .act_addr (act_addr),
      .wgt_addr (wgt_addr),
      .act_data (act_data),
      .wgt_data (wgt_data),
      .res_valid(res_valid),
      .res_idx  (res_idx),
      .res_data (res_data),
      .argmax   (argmax),
      .done     (done)
   );

   always #5 clk = ~clk;

   logic [ACT_W-1:0] act_mem [N_IN];
   logic [WGT_W-1:0] wgt_mem [N_IN*N_OUT];

   always @(posedge clk) begin
      if (rd_en) begin
         act_data <= act_mem[act_addr];
         wgt_data <= wgt_mem[wgt_addr];
      end
   end

   typedef struct packed {
      logic [3:0]  idx;
      logic [31:0] data;
   } exp_t;

   exp_t       exp_q[$];
   logic [3:0] exp_argmax;
   int         n_assert = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         t_start  = 0;
   int         n_valid  = 0;
   int         n_done   = 0;
   int         wgt_next = 0;
   int         addr_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Output monitor: address contiguity, scoreboard pops, latency and argmax at done.
   always @(negedge clk) begin
      exp_t e;
      if (rd_en) begin
         if (int'(wgt_addr) != wgt_next || int'(act_addr) != wgt_next % N_IN) addr_err++;
         wgt_next++;
      end
      if (res_valid) begin
         n_valid++;
         check("res_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("res_idx", res_idx, e.idx);
            check("res_data", res_data, e.data);
            check("res_latency", cyc - t_start, (int'(res_idx) + 1) * (N_IN + 2));
         end
      end
      if (done) begin
         n_done++;
         check("done_latency", cyc - t_start, PASS_CYC);
         check("argmax", argmax, exp_argmax);
      end
   end

   task automatic drive_start();
      @(negedge clk);
      start    = 1'b1;
      t_start  = cyc;
      wgt_next = 0;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int d0 = n_done;
      int k  = 0;
      while (n_done == d0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("done_seen", n_done != d0, 1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_rd_en"}, rd_en, 0);
      check({tag, "_res_valid"}, res_valid, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_act_addr"}, act_addr, 0);
      check({tag, "_wgt_addr"}, wgt_addr, 0);
      check({tag, "_res_idx"}, res_idx, 0);
      check({tag, "_res_data"}, res_data, 0);
      check({tag, "_argmax"}, argmax, 0);
   endtask

   // Reference dot products from the memory contents.
   task automatic build_expected();
      logic [ACC_W-1:0]        acc;
      logic signed [ACC_W-1:0] w;
      logic [ACC_W-1:0]        a;
      logic signed [31:0]      best;
      exp_q.delete();
      best = 0;
      for (int n = 0; n < N_OUT; n++) begin
         acc = '0;
         for (int m = 0; m < N_IN; m++) begin
            w   = ACC_W'($signed(wgt_mem[n*N_IN+m]));
            a   = {32'b0, act_mem[m]};
            acc = acc + ACC_W'(w * $signed(a));
         end
         exp_q.push_back({4'(n), acc[ACC_W-1 -: 32]});
         if (n == 0 || $signed(acc[ACC_W-1 -: 32]) > best) begin
            best       = $signed(acc[ACC_W-1 -: 32]);
            exp_argmax = 4'(n);
         end
      end
   endtask

   task automatic pass_summary(input string tag, input int v0, input int d0);
      check({tag, "_n_valid"}, n_valid - v0, N_OUT);
      check({tag, "_n_done"}, n_done - d0, 1);
      check({tag, "_addr_contig"}, addr_err, 0);
      check({tag, "_addr_count"}, wgt_next, N_IN * N_OUT);
      check({tag, "_queue_empty"}, exp_q.size(), 0);
   endtask

   initial begin
      int v0;
      int d0;
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;

      // All activations 2^68, all weights 1 -> 576 per neuron, argmax 0 by tie rule.
      for (int m = 0; m < N_IN; m++) act_mem[m] = 69'h1 << 68;
      for (int i = 0; i < N_IN * N_OUT; i++) wgt_mem[i] = 32'd1;
      for (int k = 0; k < N_OUT; k++) exp_q.push_back({4'(k), 32'd576});
      exp_argmax = 4'd0;
      v0 = n_valid; d0 = n_done; addr_err = 0;
      drive_start();
      check("run_busy", busy, 1);
      check("run_rd_en", rd_en, 1);
      wait_done(PASS_CYC + 20);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("fin_busy_clear", busy, 0);
      pass_summary("uniform", v0, d0);

      // Neuron k weights k, neuron 3 weights -1.
      exp_q.delete();
      for (int k = 0; k < N_OUT; k++) begin
         for (int m = 0; m < N_IN; m++) wgt_mem[k*N_IN+m] = (k == 3) ? 32'hFFFF_FFFF : 32'(k);
         exp_q.push_back({4'(k), (k == 3) ? 32'hFFFF_FDC0 : 32'(576 * k)});
      end
      exp_argmax = 4'd9;
      v0 = n_valid; d0 = n_done; addr_err = 0;
      drive_start();
      wait_done(PASS_CYC + 20);
      repeat (2) @(negedge clk);
      pass_summary("ramp", v0, d0);
      check("argmax_hold_idle", argmax, 9);

      // All weights 0, with an extra start mid-pass that must be ignored.
      exp_q.delete();
      for (int i = 0; i < N_IN * N_OUT; i++) wgt_mem[i] = 32'd0;
      for (int k = 0; k < N_OUT; k++) exp_q.push_back({4'(k), 32'd0});
      exp_argmax = 4'd0;
      v0 = n_valid; d0 = n_done; addr_err = 0;
      drive_start();
      while (cyc < t_start + 500) @(negedge clk);
      check("argmax_hold_run", argmax, 9);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(PASS_CYC + 20);
      repeat (1200) @(negedge clk);
      pass_summary("zero_restart", v0, d0);

      // Random data, reset at T+3000, then a complete fresh pass.
      for (int m = 0; m < N_IN; m++) act_mem[m] = {$urandom, $urandom, $urandom};
      for (int i = 0; i < N_IN * N_OUT; i++) wgt_mem[i] = $urandom;
      build_expected();
      v0 = n_valid; d0 = n_done; addr_err = 0;
      drive_start();
      while (cyc < t_start + 3000) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_idle_outputs("midreset");
      check("midreset_emitted", n_valid - v0, 2);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("midreset_no_done", n_done - d0, 0);
      check("midreset_idle", busy, 0);

      build_expected();
      v0 = n_valid; d0 = n_done; addr_err = 0;
      drive_start();
      wait_done(PASS_CYC + 20);
      repeat (2) @(negedge clk);
      pass_summary("random", v0, d0);

      // Reset wins over a simultaneous start.
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      check("rst_start_busy", busy, 0);
      check("rst_start_rd_en", rd_en, 0);
      repeat (3) @(negedge clk);
      check("rst_start_idle", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fc_sequencer.md
FC_SEQUENCER -- requirements
Module: fc_sequencer

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
  N_IN    1152  inputs per neuron (12*12*8 pooled activations)
  N_OUT   10    output neurons
  ACT_W   69    activation width, unsigned
  WGT_W   32    weight width, signed
  ACC_W   101   accumulator width (ACT_W+WGT_W)
REQ-002 SHALL have ports, one per line: name  direction  width  meaning:
  clk       in   1      clock
  rst       in   1      reset: synchronous, active-high; clock clk
  start     in   1      begin one full inference pass
  busy      out  1      pass in progress
  rd_en     out  1      read strobe to activation and weight memories
  act_addr  out  11     activation index m
  wgt_addr  out  14     weight index neuron*N_IN+m
  act_data  in   ACT_W  activation, valid 1 cycle after rd_en
  wgt_data  in   WGT_W  signed weight, valid 1 cycle after rd_en
  res_valid out  1      one-cycle result strobe
  res_idx   out  4      neuron index of res_data
  res_data  out  32     acc[ACC_W-1:ACC_W-32]
  argmax    out  4      index of largest res_data, valid when done
  done      out  1      one-cycle pass-complete pulse

Function
REQ-003 SHALL implement FSM states IDLE, RUN, DRAIN, EMIT, FIN.
REQ-004 IDLE: busy=0; start=1 -> RUN next cycle with neuron=0, m=0, acc=0, best=0.
REQ-005 RUN: rd_en=1, act_addr=m, wgt_addr=neuron*N_IN+m; m increments each cycle; at m=N_IN-1 -> DRAIN.
REQ-006 Each cycle after an rd_en cycle (RUN after first, and DRAIN) SHALL add wgt_data * zero-extended act_data, sign-extended to ACC_W, to acc; overflow wraps modulo 2^ACC_W.
REQ-007 DRAIN: rd_en=0; performs final accumulate; -> EMIT.
REQ-008 EMIT: res_valid=1, res_idx=neuron, res_data=acc[ACC_W-1:ACC_W-32]; acc cleared; best/argmax updated; if neuron=N_OUT-1 -> FIN, else neuron+1, m=0 -> RUN.
REQ-009 Argmax SHALL compare res_data as signed; strictly greater replaces; ties keep lower index; neuron 0 always loads best.
REQ-010 FIN: done=1 for exactly one cycle, argmax holds final value; -> IDLE.
REQ-011 busy=1 in RUN, DRAIN, EMIT, FIN.
REQ-012 start while busy SHALL be ignored (no restart, no queueing).
REQ-013 Latency: start sampled in cycle T -> done in cycle T+1+N_OUT*(N_IN+2) (T+11541 at defaults); res_valid for neuron k at T+(k+1)*(N_IN+2).
REQ-014 rd_en, res_valid, done SHALL be 0 outside the states stated above; act_addr/wgt_addr hold last value when rd_en=0.
REQ-015 argmax SHALL hold its value from done until the next EMIT of neuron 0.

Reset
REQ-016 rst=1 SHALL force IDLE, busy=0, rd_en=0, res_valid=0, done=0, act_addr=0, wgt_addr=0, res_idx=0, res_data=0, argmax=0, acc=0 on next clk edge, including mid-pass.
REQ-017 rst SHALL take priority over start in the same cycle.

Verification
REQ-018 All act=2^68, all wgt=1, start -> 10 res_valid pulses, res_data=576 each, argmax=0, done at T+11541.
REQ-019 Neuron k weights=k, act=2^68 -> res_data=576*k, argmax=9; neuron 3 weights=-1 -> res_data=0xFFFFFDC0.
REQ-020 All weights 0 -> every res_data=0, argmax=0 (tie rule).
REQ-021 start pulsed again at T+500 -> ignored; exactly 10 res_valid, one done; wgt_addr sequence 0..11519 contiguous.
REQ-022 rst asserted at T+3000 -> all outputs 0 next cycle, no done; new start gives full correct pass.
REQ-023 start and rst same cycle -> remains IDLE, busy=0.
